// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//
// Time-multiplexed seven-segment display controller for a common-anode
// display. It steps through the digits on the single-cycle `tick` strobe
// from the upstream 1 ms pulse generator. Each digit stays lit for
// HOLD_TICKS ticks, so one full frame lasts DIGITS*HOLD_TICKS ticks.
//
// A loaded value is held pending. It is committed to the display registers
// only at the frame wrap (the last digit advancing back to digit 0), so a
// number never tears part-way through a scan. A load that lands exactly on
// the wrap edge goes straight to the display.
//
// All outputs are registered. They are computed from the post-update state,
// so a qualifying tick at edge N is visible at edge N+1.
//
// Parameters:
//   DIGITS      number of scanned digits, 2..8
//   HOLD_TICKS  ticks each digit stays lit, 1..255
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high reset; has priority over tick/load
//   tick   in   single-cycle strobe from the 1 ms pulse generator
//   load   in   capture value/dp on this edge
//   value  in   [4*DIGITS] hex nibbles; nibble 0 is the rightmost digit
//   dp     in   [DIGITS] decimal-point request per digit, 1 = lit
//   an     out  [DIGITS] anode enables, active low, one-hot-low
//   seg    out  [7] cathodes {g,f,e,d,c,b,a}, active low
//   dp_n   out  decimal-point cathode, active low
//   frame  out  one-cycle pulse in the first output cycle of each new frame
//
// Build option:
//   SEG_LZB_EN  when defined, enables leading-zero blanking. Any digit above
//               the highest nonzero nibble is dark (seg = 7F, dp_n = 1).
//               Digit 0 is never blanked. Anode scanning is unaffected.
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int DIGITS     = 4,
  parameter int HOLD_TICKS = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic                  frame
);

  localparam int              IDX_W     = (DIGITS > 2) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [7:0]       HCNT_LAST = 8'(HOLD_TICKS - 1);
  localparam logic [6:0]       SEG_DARK  = 7'h7F;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Active-low hex decode, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Select the nibble belonging to digit `sel`.
  function automatic logic [3:0] pick_nib(input logic [4*DIGITS-1:0] v,
                                          input logic [IDX_W-1:0]    sel);
    logic [3:0] n;
    n = 4'h0;
    for (int d = 0; d < DIGITS; d++) begin
      if (sel == IDX_W'(d)) n = v[4*d +: 4];
    end
    return n;
  endfunction

  // Select the decimal-point request belonging to digit `sel`.
  function automatic logic pick_dp(input logic [DIGITS-1:0] p,
                                   input logic [IDX_W-1:0]  sel);
    logic b;
    b = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (sel == IDX_W'(d)) b = p[d];
    end
    return b;
  endfunction

  // One-hot-low anode pattern for digit `sel`.
  function automatic logic [DIGITS-1:0] anode_of(input logic [IDX_W-1:0] sel);
    logic [DIGITS-1:0] a;
    for (int d = 0; d < DIGITS; d++) begin
      a[d] = (sel != IDX_W'(d));
    end
    return a;
  endfunction

`ifdef SEG_LZB_EN
  // A digit is blanked when it sits above the highest nonzero nibble.
  // An all-zero value leaves the highest index at 0, so digit 0 always shows.
  function automatic logic lzb_blank(input logic [4*DIGITS-1:0] v,
                                     input logic [IDX_W-1:0]    sel);
    logic [IDX_W-1:0] hi;
    hi = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (v[4*d +: 4] != 4'h0) hi = IDX_W'(d);
    end
    return (sel > hi);
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0]    idx,      idx_nxt;
  logic [7:0]          hcnt,     hcnt_nxt;
  logic                pend,     pend_nxt;
  logic [4*DIGITS-1:0] pend_val, pend_val_nxt;
  logic [DIGITS-1:0]   pend_dp,  pend_dp_nxt;
  logic [4*DIGITS-1:0] disp_val, disp_val_nxt;
  logic [DIGITS-1:0]   disp_dp,  disp_dp_nxt;
  logic                wrap;

  // Output values computed from the post-update state, registered below.
  logic [DIGITS-1:0]   an_p0;
  logic [6:0]          seg_p0;
  logic                dp_n_p0;
  logic                frame_p0;

  // ---------------------------------------------------------------------------
  // Next-state logic: scan counters and the pending/display value handoff
  // ---------------------------------------------------------------------------
  always_comb begin
    idx_nxt      = idx;
    hcnt_nxt     = hcnt;
    pend_nxt     = pend;
    pend_val_nxt = pend_val;
    pend_dp_nxt  = pend_dp;
    disp_val_nxt = disp_val;
    disp_dp_nxt  = disp_dp;
    wrap         = 1'b0;

    if (tick) begin
      if (hcnt == HCNT_LAST) begin
        hcnt_nxt = 8'd0;
        if (idx == IDX_LAST) begin
          idx_nxt = '0;
          wrap    = 1'b1;
        end else begin
          idx_nxt = idx + IDX_W'(1);
        end
      end else begin
        hcnt_nxt = hcnt + 8'd1;
      end
    end

    if (wrap) begin
      // A load on the wrap edge bypasses the pending register entirely.
      if (load) begin
        disp_val_nxt = value;
        disp_dp_nxt  = dp;
        pend_nxt     = 1'b0;
      end else if (pend) begin
        disp_val_nxt = pend_val;
        disp_dp_nxt  = pend_dp;
        pend_nxt     = 1'b0;
      end
    end else if (load) begin
      // Last load before the wrap wins.
      pend_val_nxt = value;
      pend_dp_nxt  = dp;
      pend_nxt     = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // pend_val/pend_dp are not reset: they are only ever read while pend is
  // set, and reset clears pend, so any stale pending data is discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx      <= '0;
      hcnt     <= 8'd0;
      pend     <= 1'b0;
      disp_val <= '0;
      disp_dp  <= '0;
    end else begin
      idx      <= idx_nxt;
      hcnt     <= hcnt_nxt;
      pend     <= pend_nxt;
      disp_val <= disp_val_nxt;
      disp_dp  <= disp_dp_nxt;
    end
    pend_val <= pend_val_nxt;
    pend_dp  <= pend_dp_nxt;
  end

  // ---------------------------------------------------------------------------
  // Output logic: decode the digit that will be lit after this edge
  // ---------------------------------------------------------------------------
  always_comb begin
    logic blank;
`ifdef SEG_LZB_EN
    blank = lzb_blank(disp_val_nxt, idx_nxt);
`else
    blank = 1'b0;
`endif
    an_p0    = anode_of(idx_nxt);
    seg_p0   = blank ? SEG_DARK : hex7(pick_nib(disp_val_nxt, idx_nxt));
    dp_n_p0  = blank ? 1'b1 : ~pick_dp(disp_dp_nxt, idx_nxt);
    // The wrap edge is exactly the edge that brings digit 0 back, so frame
    // can never fire on the first digit-0 display after reset.
    frame_p0 = wrap;
  end

  // ---------------------------------------------------------------------------
  // Stage 1: output registers; reset forces the display dark
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      an    <= '1;
      seg   <= SEG_DARK;
      dp_n  <= 1'b1;
      frame <= 1'b0;
    end else begin
      an    <= an_p0;
      seg   <= seg_p0;
      dp_n  <= dp_n_p0;
      frame <= frame_p0;
    end
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed seven-segment display controller sitting directly downstream of the 1 ms pulse generator. It consumes the generator's single-cycle `tick` strobe to step through the digits of a common-anode display. It holds a loadable hex value and drives registered, active-low anode, segment and decimal-point lines. New values are committed only at frame boundaries so a displayed number never tears mid-scan.

## Interface
- `DIGITS`, 4: number of digits scanned, legal 2..8.
- `HOLD_TICKS`, 1: ticks each digit stays lit, legal 1..255.

- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `tick` in 1: single-cycle strobe from the upstream 1 ms pulse generator.
- `load` in 1: capture `value` and `dp` on this edge.
- `value` in 4*DIGITS: hex nibbles; nibble 0 (`[3:0]`) is digit 0, the rightmost digit.
- `dp` in DIGITS: decimal point request per digit, 1 = lit.
- `an` out DIGITS: anode enables, active low, one-hot-low.
- `seg` out 7: cathodes `{g,f,e,d,c,b,a}`, active low.
- `dp_n` out 1: decimal-point cathode, active low.
- `frame` out 1: one-cycle pulse in the first output cycle of each new frame.

## Operation
- State:
  - Digit index `idx`: width max(1, clog2(DIGITS)).
  - Hold counter `hcnt`: 8 bits.
  - `pend_val` / `pend_dp` registers with a `pend` flag.
  - `disp_val` / `disp_dp` display registers.
- `load` at edge N: `pend_val`/`pend_dp` are set to `value`/`dp` and `pend` is set to 1. A later `load` before commit overwrites the pending value; the last one wins.
- `tick` at edge N:
  - If `hcnt == HOLD_TICKS-1`: `hcnt` is set to 0 and `idx` advances.
  - Otherwise `hcnt` increments.
  - Cycles without `tick` change neither counter.
- Wrap occurs when `idx == DIGITS-1` advances to 0.
  - At the wrap edge, if `pend` is set, `disp` takes `pend` and `pend` is cleared.
  - If `load` coincides with the wrap edge, the incoming `value`/`dp` go straight to `disp` and `pend` is cleared.
- Output registers, updated every edge from post-update state:
  - `an`: all ones except bit `idx`, which is 0.
  - `seg`: hex decode of nibble `idx` of `disp_val`.
  - `dp_n`: inverse of `disp_dp[idx]`.
- Hex decode, active low: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- `frame` is 1 for exactly the single output cycle in which `an` first shows digit 0 after a wrap. It is never asserted for the first digit-0 display after reset.

## Timing
- Reset values:
  - `an` = all ones; `seg` = 7F; `dp_n` = 1; `frame` = 0.
  - `idx` = 0; `hcnt` = 0; `pend` = 0; `disp_val` = 0; `disp_dp` = 0.
- `reset` has priority over `tick` and `load`.
- Asserting `reset` mid-frame discards pending data. Outputs go dark on the next edge.
- First clock after reset deasserts: `an` shows digit 0 (bit 0 low) with `seg` = 40.
- Latency from a qualifying `tick` at edge N to the new `an`/`seg`/`dp_n`/`frame`: edge N+1.
- A committed value is visible starting with digit 0 of the frame that begins at the wrap.
- A digit is lit for `HOLD_TICKS` tick periods (nominally `HOLD_TICKS` ms), and the frame period is `DIGITS*HOLD_TICKS` ticks.
- `tick` asserted on consecutive cycles is legal: each assertion counts.

## Configuration
- `SEG_LZB_EN` defined enables leading-zero blanking.
  - Any digit above the highest nonzero nibble of `disp_val` drives `seg` = 7F and `dp_n` = 1.
  - `an` still scans normally, so timing is unchanged.
  - Digit 0 is never blanked.
- `SEG_LZB_EN` undefined: every digit is decoded, so a zero nibble shows 40.

## Test plan
- **Reset:** hold `reset` 3 cycles → `an`=F, `seg`=7F, `dp_n`=1, `frame`=0. One cycle after release → `an`=1110, `seg`=40.
- **Deferred load** (DIGITS=4, HOLD_TICKS=1): `load` 16'h12AF at `idx`=1 → display still shows 0 until wrap. On wrap, `frame`=1 with `an`=1110, `seg`=0E. Subsequent ticks show `seg` 08, 24, 79 on `an` 1101, 1011, 0111.
- **Load/wrap collision:** `load` 16'h0C00 on the same edge as the wrap tick → next cycle `frame`=1 and the digit-0 `seg`=40. The digit-2 slot then shows 46, and `pend`=0.
- **Hold count** (HOLD_TICKS=3): 9 ticks spaced 5 cycles apart → `idx` advances only on ticks 3, 6 and 9. Cycles without `tick` leave `an` unchanged.
- **Blanking:** `value` 16'h0005 → with `SEG_LZB_EN`, digits 1–3 show `seg`=7F; without it they show 40. `value`=0 with `SEG_LZB_EN` → digit 0 still shows 40.
- **Reset mid-frame:** `load` pending, reset at `idx`=2 → outputs go dark next edge. After release, digit 0 shows 40 and the pending value is never displayed.
